// File: rtl/dot4_seq.sv
// Sequential four-element single-precision dot product. Drives one shared
// multiplier and one shared adder over stb/ack channels, one operation at a time.
module dot4_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_stb,
  output logic        in_ack,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic [31:0] b0,
  input  logic [31:0] b1,
  input  logic [31:0] b2,
  input  logic [31:0] b3,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_a_stb,
  output logic        mul_b_stb,
  input  logic        mul_a_ack,
  input  logic        mul_b_ack,
  input  logic [31:0] mul_z,
  input  logic        mul_z_stb,
  output logic        mul_z_ack,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_a_stb,
  output logic        add_b_stb,
  input  logic        add_a_ack,
  input  logic        add_b_ack,
  input  logic [31:0] add_z,
  input  logic        add_z_stb,
  output logic        add_z_ack,
  output logic [31:0] ans,
  output logic        ans_stb,
  input  logic        ans_ack,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_SEND,
    S_MUL_WAIT,
    S_ADD_SEND,
    S_ADD_WAIT,
    S_OUT
  } state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [31:0] r_a [4];
  logic [31:0] r_b [4];
  logic [31:0] r_acc;
  logic [31:0] r_prod;
  logic [31:0] r_ans;
  logic        r_mul_a_sent;
  logic        r_mul_b_sent;
  logic        r_add_a_sent;
  logic        r_add_b_sent;

  logic        w_mul_a_done;
  logic        w_mul_b_done;
  logic        w_add_a_done;
  logic        w_add_b_done;

  // Every output is a decode of registered state, so no input reaches an output
  // combinationally; strobes fall as soon as their own sent flag is set.
  assign in_ack    = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign mul_a     = r_a[r_idx];
  assign mul_b     = r_b[r_idx];
  assign mul_a_stb = (r_state == S_MUL_SEND) && !r_mul_a_sent;
  assign mul_b_stb = (r_state == S_MUL_SEND) && !r_mul_b_sent;
  assign mul_z_ack = (r_state == S_MUL_WAIT);
  assign add_a     = r_acc;
  assign add_b     = r_prod;
  assign add_a_stb = (r_state == S_ADD_SEND) && !r_add_a_sent;
  assign add_b_stb = (r_state == S_ADD_SEND) && !r_add_b_sent;
  assign add_z_ack = (r_state == S_ADD_WAIT);
  assign ans       = r_ans;
  assign ans_stb   = (r_state == S_OUT);

  assign w_mul_a_done = r_mul_a_sent || (mul_a_stb && mul_a_ack);
  assign w_mul_b_done = r_mul_b_sent || (mul_b_stb && mul_b_ack);
  assign w_add_a_done = r_add_a_sent || (add_a_stb && add_a_ack);
  assign w_add_b_done = r_add_b_sent || (add_b_stb && add_b_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_idx        <= 2'd0;
      r_acc        <= 32'd0;
      r_prod       <= 32'd0;
      r_ans        <= 32'd0;
      r_mul_a_sent <= 1'b0;
      r_mul_b_sent <= 1'b0;
      r_add_a_sent <= 1'b0;
      r_add_b_sent <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_a[i] <= 32'd0;
        r_b[i] <= 32'd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_stb) begin
            r_a[0]  <= a0;
            r_a[1]  <= a1;
            r_a[2]  <= a2;
            r_a[3]  <= a3;
            r_b[0]  <= b0;
            r_b[1]  <= b1;
            r_b[2]  <= b2;
            r_b[3]  <= b3;
            r_idx   <= 2'd0;
            r_state <= S_MUL_SEND;
          end
        end
        S_MUL_SEND: begin
          if (w_mul_a_done && w_mul_b_done) begin
            r_mul_a_sent <= 1'b0;
            r_mul_b_sent <= 1'b0;
            r_state      <= S_MUL_WAIT;
          end else begin
            r_mul_a_sent <= w_mul_a_done;
            r_mul_b_sent <= w_mul_b_done;
          end
        end
        S_MUL_WAIT: begin
          if (mul_z_stb) begin
            // The first product seeds the accumulator directly so -0 survives.
            if (r_idx == 2'd0) begin
              r_acc   <= mul_z;
              r_idx   <= 2'd1;
              r_state <= S_MUL_SEND;
            end else begin
              r_prod  <= mul_z;
              r_state <= S_ADD_SEND;
            end
          end
        end
        S_ADD_SEND: begin
          if (w_add_a_done && w_add_b_done) begin
            r_add_a_sent <= 1'b0;
            r_add_b_sent <= 1'b0;
            r_state      <= S_ADD_WAIT;
          end else begin
            r_add_a_sent <= w_add_a_done;
            r_add_b_sent <= w_add_b_done;
          end
        end
        S_ADD_WAIT: begin
          if (add_z_stb) begin
            r_acc <= add_z;
            if (r_idx == 2'd3) begin
              r_ans   <= add_z;
              r_state <= S_OUT;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= S_MUL_SEND;
            end
          end
        end
        S_OUT: begin
          if (ans_ack) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
